lane_translater_rx: RTL and testbench
=====================================

// Module: lane_translater_rx
// PURPOSE
// - Receive side of the QoS PCIe lane translater interface. Consumes in_1/in_2 serial lanes under
//   control of ENB, selector1 and selector2, deserialises MSB-first into WIDTH-bit words.
// - Buffers words in a DEPTH-entry FIFO; downstream QoS logic drains it with a valid/ready handshake.
// PARAMETERS
// - WIDTH  8  word width in bits; even, >= 4
// - DEPTH  4  output FIFO entries; power of two, >= 2
// PORTS
// - clk         in   1      single clock, all state on rising edge
// - reset_L     in   1      asynchronous, active-low reset
// - ENB         in   1      receive enable; low = idle, partial word discarded
// - in_1        in   1      serial lane 1
// - in_2        in   1      serial lane 2
// - selector1   in   1      primary lane: 0 = in_1, 1 = in_2
// - selector2   in   1      lane mode: 0 = single-lane (1 bit/clk), 1 = dual-lane (2 bits/clk)
// - ready_in    in   1      downstream accepts data_out this cycle
// - data_out    out  WIDTH  FIFO head word
// - valid_out   out  1      data_out holds a valid word
// - overflow    out  1      sticky: a completed word was dropped (FIFO full)
// - fifo_count  out  log2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// - Reset (reset_L low, async): data_out=0, valid_out=0, overflow=0, fifo_count=0, FSM=IDLE,
//   shift register and bit counter 0. All outputs are registered or decoded from registers only.
// - FSM: IDLE -> SHIFT on rising edge with ENB=1; the bit(s) present on that edge are the first sampled.
//   SHIFT -> SHIFT while ENB=1; SHIFT -> IDLE when ENB=0 (partial word dropped, counter cleared).
// - selector1/selector2 sampled on the word's first bit edge and held for the whole word;
//   changes mid-word take effect at the next word.
// - Single-lane: shift in primary lane bit each clk; word done after WIDTH edges.
// - Dual-lane: shift in {primary, secondary} per clk (primary = higher bit); done after WIDTH/2 edges.
// - Words are back-to-back: the edge after the last bit of word n is bit 0 of word n+1 (no gap).
// - Completed word pushed into FIFO on the edge sampling its last bit; valid_out high the next cycle
//   (latency 1 clk after last bit when FIFO empty).
// - Pop when valid_out && ready_in; next entry (if any) appears the following cycle, no bubble.
// - Full FIFO + word completion + no pop: word dropped, overflow set (stays set until reset).
// - Full FIFO + word completion + pop same edge: push accepted, count unchanged, no overflow.
// - Empty FIFO: valid_out=0, data_out holds last value; ready_in ignored.
// - FIFO pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH.
// - FIFO draining is independent of ENB.
// CONFIGURATION
// - LANE_TRANSLATER_PARITY_EN defined: after the last data bit one extra SHIFT cycle samples an
//   even-parity bit on the primary lane (both modes). Word still pushed (on the parity edge, +1 clk
//   latency); extra output parity_err (1 bit, reset 0) pulses high exactly one cycle,
//   concurrent with the push, when parity mismatches. Next word starts the edge after the parity bit.
// - Not defined: no parity cycle, no parity_err port; words back-to-back as above.
// TESTING
// - Reset mid-word (after 3 bits, single-lane) -> all outputs 0, next word assembles from bit 0.
// - Single-lane, selector1=0, in_1 = 1,0,1,0,0,1,0,1 from ENB edge -> valid_out 1 clk after 8th bit,
//   data_out=8'hA5; in_2 toggling has no effect.
// - Dual-lane, selector1=1, 4 clks of {in_2,in_1} = 11,00,10,01 -> data_out=8'hC9 after 4 bit edges.
// - selector2 flipped to 1 mid-word -> current word finishes single-lane (8 clks), next word dual-lane (4 clks).
// - ready_in=0, 5 words at DEPTH=4 -> fifo_count=4, overflow=1, words 1-4 pop in order; 5th absent.
// - ENB dropped after 5 bits then reasserted -> no push, new word aligned to re-enable edge;
//   with LANE_TRANSLATER_PARITY_EN, 8'hA5 followed by parity 1 -> parity_err pulses 1 cycle.

Source files
------------

// File: rtl/lane_translater_rx_if.sv
// Output word handshake bundle for the lane translater receiver.
// master drives data/valid, slave returns ready.
interface lane_translater_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output data_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/lane_translater_rx.sv
// QoS PCIe lane translater RX: serial lanes -> WIDTH-bit words -> FIFO.
// Optional even-parity cycle per word: LANE_TRANSLATER_PARITY_EN.
module lane_translater_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     ENB,
  input  logic                     in_1,
  input  logic                     in_2,
  input  logic                     selector1,
  input  logic                     selector2,
  lane_translater_rx_if.master     rx,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef LANE_TRANSLATER_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WBITS = CW'(WIDTH);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sh_sr;
  logic [CW-1:0]    cnt_q, cnt_d, sh_cnt;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             sel1, sel2, pri, sec, first;
  logic             push;
  logic [WIDTH-1:0] pdata;
`ifdef LANE_TRANSLATER_PARITY_EN
  logic             perr_d;
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    push    = 1'b0;
    pdata   = sr_q;
`ifdef LANE_TRANSLATER_PARITY_EN
    perr_d  = 1'b0;
`endif
    first   = (state_q == IDLE) || (cnt_q == '0);
    // lane setup is latched on a word's first edge only
    sel1    = first ? selector1 : s1_q;
    sel2    = first ? selector2 : s2_q;
    pri     = sel1 ? in_2 : in_1;
    sec     = sel1 ? in_1 : in_2;
    sh_sr   = sel2 ? {sr_q[WIDTH-3:0], pri, sec}
                   : {sr_q[WIDTH-2:0], pri};
    sh_cnt  = cnt_q + (sel2 ? CW'(2) : CW'(1));
    if (!ENB) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      state_d = SHIFT;
      s1_d    = sel1;
      s2_d    = sel2;
`ifdef LANE_TRANSLATER_PARITY_EN
      if (cnt_q == WBITS) begin
        push   = 1'b1;
        pdata  = sr_q;
        perr_d = ^{sr_q, pri};
        cnt_d  = '0;
      end else begin
        sr_d  = sh_sr;
        cnt_d = sh_cnt;
      end
`else
      sr_d  = sh_sr;
      cnt_d = sh_cnt;
      if (sh_cnt == WBITS) begin
        push  = 1'b1;
        pdata = sh_sr;
        cnt_d = '0;
      end
`endif
    end
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, rptr_n;
  logic [AW:0]      count_q, count_n;
  logic             pop, full, wr, drop;
  logic [WIDTH-1:0] head_n;

  assign pop  = rx.valid_out && rx.ready_in;
  assign full = (count_q == FULL);
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;
  assign fifo_count = count_q;

  always_comb begin
    rptr_n  = pop ? rptr_q + AW'(1) : rptr_q;
    count_n = count_q;
    case ({wr, pop})
      2'b10:   count_n = count_q + (AW + 1)'(1);
      2'b01:   count_n = count_q - (AW + 1)'(1);
      default: count_n = count_q;
    endcase
    // a push into an empty slot becomes the head without a bubble
    head_n = (wr && (wptr_q == rptr_n)) ? pdata : mem[rptr_n];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= pdata;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rx.data_out  <= '0;
      rx.valid_out <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      rptr_q       <= rptr_n;
      count_q      <= count_n;
      rx.valid_out <= (count_n != '0);
      overflow     <= overflow | drop;
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (count_n != '0) rx.data_out <= head_n;
    end
  end

`ifdef LANE_TRANSLATER_PARITY_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) parity_err <= 1'b0;
    else          parity_err <= push && perr_d;
  end
`endif

endmodule

// File: tb/tb_lane_translater_rx.sv
// Directed bench for lane_translater_rx (WIDTH=8, DEPTH=4).
// Also builds with LANE_TRANSLATER_PARITY_EN defined.
module tb_lane_translater_rx;

  logic       clk = 1'b0;
  logic       reset_L, ENB, in_1, in_2;
  logic       selector1, selector2;
  logic       overflow;
  logic [2:0] fifo_count;
`ifdef LANE_TRANSLATER_PARITY_EN
  logic       parity_err;
`endif
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;
  logic [7:0] wv [5];

  lane_translater_rx_if #(.WIDTH(8)) bus ();

  lane_translater_rx #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .ENB        (ENB),
    .in_1       (in_1),
    .in_2       (in_2),
    .selector1  (selector1),
    .selector2  (selector2),
    .rx         (bus),
    .overflow   (overflow),
    .fifo_count (fifo_count)
`ifdef LANE_TRANSLATER_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p1, input logic pri,
                       input logic sec);
    if (p1) begin
      in_2 = pri;
      in_1 = sec;
    end else begin
      in_1 = pri;
      in_2 = sec;
    end
  endtask

  task automatic send_single(input logic [7:0] w,
                             input logic p1);
    for (int i = 7; i >= 0; i--) begin
      drive(p1, w[i], 1'($urandom));
      tick();
    end
`ifdef LANE_TRANSLATER_PARITY_EN
    drive(p1, ^w, 1'($urandom));
    tick();
`endif
  endtask

  task automatic send_dual(input logic [7:0] w,
                           input logic p1);
    for (int i = 3; i >= 0; i--) begin
      drive(p1, w[2*i+1], w[2*i]);
      tick();
    end
`ifdef LANE_TRANSLATER_PARITY_EN
    drive(p1, ^w, 1'($urandom));
    tick();
`endif
  endtask

  initial begin
    wv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset_L = 1'b0;
    ENB = 1'b0;
    in_1 = 1'b0;
    in_2 = 1'b0;
    selector1 = 1'b0;
    selector2 = 1'b0;
    bus.ready_in = 1'b0;
    #12;
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    reset_L = 1'b1;

    ENB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_1 = 1'b1;
      tick();
    end
    reset_L = 1'b0;
    #2;
    chk("midrst_valid", 32'(bus.valid_out), 32'h0);
    chk("midrst_count", 32'(fifo_count), 32'h0);
    chk("midrst_data", 32'(bus.data_out), 32'h0);
    reset_L = 1'b1;
    send_single(8'hA5, 1'b0);
    chk("a5_valid", 32'(bus.valid_out), 32'h1);
    chk("a5_data", 32'(bus.data_out), 32'hA5);
    chk("a5_count", 32'(fifo_count), 32'h1);
`ifdef LANE_TRANSLATER_PARITY_EN
    chk("a5_perr", 32'(parity_err), 32'h0);
`endif
    ENB = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    chk("a5_popvalid", 32'(bus.valid_out), 32'h0);
    chk("a5_popcount", 32'(fifo_count), 32'h0);
    chk("a5_hold", 32'(bus.data_out), 32'hA5);
    bus.ready_in = 1'b0;

    selector1 = 1'b1;
    selector2 = 1'b1;
    ENB = 1'b1;
    send_dual(8'hC9, 1'b1);
    chk("c9_data", 32'(bus.data_out), 32'hC9);
    chk("c9_valid", 32'(bus.valid_out), 32'h1);
    ENB = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    chk("c9_pop", 32'(fifo_count), 32'h0);
    bus.ready_in = 1'b0;

    selector1 = 1'b0;
    selector2 = 1'b0;
    ENB = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) selector2 = 1'b1;
      in_1 = wv[0][0];
      in_1 = (8'h3C >> i) & 8'h1;
      in_2 = 1'($urandom);
      tick();
    end
`ifdef LANE_TRANSLATER_PARITY_EN
    in_1 = 1'b0;
    tick();
`endif
    chk("flip_count1", 32'(fifo_count), 32'h1);
    chk("flip_data1", 32'(bus.data_out), 32'h3C);
    send_dual(8'h96, 1'b0);
    chk("flip_count2", 32'(fifo_count), 32'h2);
    ENB = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    chk("flip_data2", 32'(bus.data_out), 32'h96);
    chk("flip_count3", 32'(fifo_count), 32'h1);
    tick();
    chk("flip_empty", 32'(bus.valid_out), 32'h0);
    bus.ready_in = 1'b0;

    selector2 = 1'b0;
    ENB = 1'b1;
    for (int k = 0; k < 4; k++) send_single(wv[k], 1'b0);
    chk("full_count", 32'(fifo_count), 32'h4);
    chk("full_noovf", 32'(overflow), 32'h0);
    send_single(wv[4], 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'h4);
    chk("ovf_set", 32'(overflow), 32'h1);
    ENB = 1'b0;
    bus.ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), 32'(bus.data_out), 32'(wv[k]));
      tick();
    end
    chk("drain_count", 32'(fifo_count), 32'h0);
    chk("drain_valid", 32'(bus.valid_out), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    bus.ready_in = 1'b0;

    ENB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_1 = 1'b1;
      tick();
    end
    ENB = 1'b0;
    tick();
    chk("enb_drop", 32'(fifo_count), 32'h0);
    ENB = 1'b1;
    send_single(8'h5A, 1'b0);
    chk("realign_cnt", 32'(fifo_count), 32'h1);
    chk("realign_dat", 32'(bus.data_out), 32'h5A);

`ifdef LANE_TRANSLATER_PARITY_EN
    ENB = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    ENB = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      in_1 = (8'hA5 >> i) & 8'h1;
      tick();
    end
    in_1 = 1'b1;
    tick();
    chk("perr_pulse", 32'(parity_err), 32'h1);
    chk("perr_data", 32'(bus.data_out), 32'hA5);
    ENB = 1'b0;
    tick();
    chk("perr_clear", 32'(parity_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
